// File: rtl/qmem_pkg.sv
// qmem_pkg: shared QMEM bus widths, arbiter state type and a fixed-priority one-hot helper
package qmem_pkg;
    localparam int QAW = 32;
    localparam int QDW = 32;
    localparam int QSW = QDW / 8;
    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
    function automatic logic [31:0] onehot_prio(input logic [31:0] vec);
        return vec & (~vec + 32'd1);
    endfunction
endpackage

// File: rtl/qmem_arb_sel.sv
// qmem_arb_sel: grant selection and transfer lock; QMEM_ARB_RR_EN selects round-robin priority
module qmem_arb_sel
    import qmem_pkg::*;
#(
    parameter int MN = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [MN-1:0] i_req,
    input  logic          i_cs,
    input  logic          i_term,
    output logic [MN-1:0] o_ms
);
    arb_state_e    r_state, w_state_nxt;
    logic [MN-1:0] r_ms_q, w_ms_q_nxt, w_pick;
`ifdef QMEM_ARB_RR_EN
    logic [MN-1:0] r_last, w_req_hi;
    // requests strictly above the last winner get first pick; MSB winner wraps to all
    always_comb begin
        w_req_hi = i_req & ~((r_last << 1) - MN'(1));
        w_pick   = |w_req_hi ? MN'(onehot_prio(32'(w_req_hi))) : MN'(onehot_prio(32'(i_req)));
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) r_last <= {1'b1, {(MN-1){1'b0}}};
        else if (i_term && |o_ms) r_last <= o_ms;
`else
    always_comb w_pick = MN'(onehot_prio(32'(i_req)));
`endif
    always_comb o_ms = !rst ? '0 : (r_state == ARB_BUSY ? r_ms_q : w_pick);
    always_comb begin
        w_state_nxt = r_state;
        w_ms_q_nxt  = r_ms_q;
        if (i_cs && !i_term) begin
            w_state_nxt = ARB_BUSY;
            w_ms_q_nxt  = o_ms;
        end else if (i_term) begin
            w_state_nxt = ARB_IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_state <= ARB_IDLE;
            r_ms_q  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ms_q  <= w_ms_q_nxt;
        end
endmodule

// File: rtl/qmem_master_arbiter.sv
// qmem_master_arbiter: N-master to 1-slave QMEM arbiter (request mux, response routing); QMEM_ARB_RR_EN enables round-robin
module qmem_master_arbiter #(
    parameter int QAW = qmem_pkg::QAW,
    parameter int QDW = qmem_pkg::QDW,
    parameter int QSW = QDW / 8,
    parameter int MN  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MN-1:0]     qm_cs,
    input  logic [MN-1:0]     qm_we,
    input  logic [MN*QSW-1:0] qm_sel,
    input  logic [MN*QAW-1:0] qm_adr,
    input  logic [MN*QDW-1:0] qm_dat_w,
    output logic [MN*QDW-1:0] qm_dat_r,
    output logic [MN-1:0]     qm_ack,
    output logic [MN-1:0]     qm_err,
    output logic              qs_cs,
    output logic              qs_we,
    output logic [QSW-1:0]    qs_sel,
    output logic [QAW-1:0]    qs_adr,
    output logic [QDW-1:0]    qs_dat_w,
    input  logic [QDW-1:0]    qs_dat_r,
    input  logic              qs_ack,
    input  logic              qs_err,
    output logic [MN-1:0]     ms
);
    logic [MN-1:0] w_ms;
    qmem_arb_sel #(.MN(MN)) u_sel (
        .clk    (clk),
        .rst    (rst),
        .i_req  (qm_cs),
        .i_cs   (qs_cs),
        .i_term (qs_ack | qs_err),
        .o_ms   (w_ms)
    );
    // one-hot grant lets an AND-OR mux stand in for an indexed select
    always_comb begin
        qs_cs    = |(qm_cs & w_ms);
        qs_we    = |(qm_we & w_ms);
        qs_sel   = '0;
        qs_adr   = '0;
        qs_dat_w = '0;
        for (int i = 0; i < MN; i++) begin
            qs_sel   = qs_sel   | (qm_sel[i*QSW +: QSW]   & {QSW{w_ms[i]}});
            qs_adr   = qs_adr   | (qm_adr[i*QAW +: QAW]   & {QAW{w_ms[i]}});
            qs_dat_w = qs_dat_w | (qm_dat_w[i*QDW +: QDW] & {QDW{w_ms[i]}});
        end
    end
    assign ms       = w_ms;
    assign qm_ack   = {MN{qs_ack}} & w_ms;
    assign qm_err   = {MN{qs_err}} & w_ms;
    assign qm_dat_r = {MN{qs_dat_r}};
endmodule

// File: tb/tb_qmem_master_arbiter.sv
// tb_qmem_master_arbiter: directed vector table, round-robin sequence and randomized model check for qmem_master_arbiter
module tb_qmem_master_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  qm_cs, qm_we_b, qm_ack, qm_err, ms;
    logic [7:0]  qm_sel_b;
    logic [63:0] qm_adr_b, qm_dat_w_b, qm_dat_r;
    logic        qs_cs, qs_we, qs_ack, qs_err;
    logic [3:0]  qs_sel;
    logic [31:0] qs_adr, qs_dat_w, qs_dat_r;
    logic        we [2];
    logic [3:0]  sel [2];
    logic [31:0] adr [2];
    logic [31:0] dat [2];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          m_busy;
    int          m_own, m_last;

    always #5 clk = ~clk;

    qmem_master_arbiter #(.QAW(32), .QDW(32), .QSW(4), .MN(2)) dut (
        .clk(clk), .rst(rst), .qm_cs(qm_cs), .qm_we(qm_we_b), .qm_sel(qm_sel_b),
        .qm_adr(qm_adr_b), .qm_dat_w(qm_dat_w_b), .qm_dat_r(qm_dat_r), .qm_ack(qm_ack),
        .qm_err(qm_err), .qs_cs(qs_cs), .qs_we(qs_we), .qs_sel(qs_sel), .qs_adr(qs_adr),
        .qs_dat_w(qs_dat_w), .qs_dat_r(qs_dat_r), .qs_ack(qs_ack), .qs_err(qs_err), .ms(ms)
    );

    typedef struct {
        logic [1:0]  cs;
        logic        ack, err;
        logic [31:0] a0, a1;
        logic [1:0]  e_ms;
        logic        e_cs;
        logic [31:0] e_adr;
        logic [1:0]  e_ack, e_err;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pack_bus();
        qm_we_b    = {we[1], we[0]};
        qm_sel_b   = {sel[1], sel[0]};
        qm_adr_b   = {adr[1], adr[0]};
        qm_dat_w_b = {dat[1], dat[0]};
    endtask

    // reference grant: locked owner, else first requester scanning from the priority start
    function automatic int pick(input logic [1:0] cs);
        if (m_busy) return m_own;
        for (int k = 0; k < 2; k++) begin
`ifdef QMEM_ARB_RR_EN
            int i = (m_last + 1 + k) % 2;
`else
            int i = k;
`endif
            if (cs[i]) return i;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        qm_cs = 2'b00; qs_ack = 1'b0; qs_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_busy = 1'b0; m_own = -1; m_last = 1;
    endtask

    initial begin
        vec_t v [23];
        we[0] = 1'b1; sel[0] = 4'hF; adr[0] = 32'h0; dat[0] = 32'hA0A0A0A0;
        we[1] = 1'b0; sel[1] = 4'h3; adr[1] = 32'h0; dat[1] = 32'hB1B1B1B1;
        pack_bus();
        qs_dat_r = 32'hDEADBEEF;
        rst = 1'b1; qm_cs = 2'b00; qs_ack = 1'b0; qs_err = 1'b0;

        // reset with both masters requesting and a stray ack/err
        @(negedge clk);
        rst = 1'b0; qm_cs = 2'b11; qs_ack = 1'b1; qs_err = 1'b1;
        #1;
        chk("rst_qs_cs", qs_cs, 0);
        chk("rst_ms", ms, 0);
        chk("rst_ack", qm_ack, 0);
        chk("rst_err", qm_err, 0);
        @(negedge clk);
        rst = 1'b1; qs_ack = 1'b0; qs_err = 1'b0;
        #1;
        chk("post_rst_ms", ms, 2'b01);
        qm_cs = 2'b00;

`ifndef QMEM_ARB_RR_EN
        v[0]  = '{2'b10, 1'b0, 1'b0, 32'h0,  32'h1234, 2'b10, 1'b1, 32'h1234, 2'b00, 2'b00};
        v[1]  = '{2'b10, 1'b0, 1'b0, 32'h0,  32'h1234, 2'b10, 1'b1, 32'h1234, 2'b00, 2'b00};
        v[2]  = '{2'b10, 1'b0, 1'b0, 32'h0,  32'h1234, 2'b10, 1'b1, 32'h1234, 2'b00, 2'b00};
        v[3]  = '{2'b10, 1'b1, 1'b0, 32'h0,  32'h1234, 2'b10, 1'b1, 32'h1234, 2'b10, 2'b00};
        v[4]  = '{2'b00, 1'b0, 1'b0, 32'h0,  32'h1234, 2'b00, 1'b0, 32'h0,    2'b00, 2'b00};
        v[5]  = '{2'b11, 1'b0, 1'b0, 32'h100, 32'h200, 2'b01, 1'b1, 32'h100,  2'b00, 2'b00};
        v[6]  = '{2'b11, 1'b1, 1'b0, 32'h100, 32'h200, 2'b01, 1'b1, 32'h100,  2'b01, 2'b00};
        v[7]  = '{2'b10, 1'b0, 1'b0, 32'h100, 32'h200, 2'b10, 1'b1, 32'h200,  2'b00, 2'b00};
        v[8]  = '{2'b10, 1'b1, 1'b0, 32'h100, 32'h200, 2'b10, 1'b1, 32'h200,  2'b10, 2'b00};
        v[9]  = '{2'b10, 1'b0, 1'b0, 32'h100, 32'h200, 2'b10, 1'b1, 32'h200,  2'b00, 2'b00};
        v[10] = '{2'b11, 1'b0, 1'b0, 32'h100, 32'h200, 2'b10, 1'b1, 32'h200,  2'b00, 2'b00};
        v[11] = '{2'b11, 1'b0, 1'b0, 32'h100, 32'h200, 2'b10, 1'b1, 32'h200,  2'b00, 2'b00};
        v[12] = '{2'b11, 1'b0, 1'b0, 32'h100, 32'h200, 2'b10, 1'b1, 32'h200,  2'b00, 2'b00};
        v[13] = '{2'b11, 1'b1, 1'b0, 32'h100, 32'h200, 2'b10, 1'b1, 32'h200,  2'b10, 2'b00};
        v[14] = '{2'b01, 1'b0, 1'b1, 32'h10,  32'h200, 2'b01, 1'b1, 32'h10,   2'b00, 2'b01};
        v[15] = '{2'b10, 1'b1, 1'b0, 32'h10,  32'h200, 2'b10, 1'b1, 32'h200,  2'b10, 2'b00};
        v[16] = '{2'b01, 1'b0, 1'b0, 32'h10,  32'h200, 2'b01, 1'b1, 32'h10,   2'b00, 2'b00};
        v[17] = '{2'b11, 1'b1, 1'b1, 32'h10,  32'h200, 2'b01, 1'b1, 32'h10,   2'b01, 2'b01};
        v[18] = '{2'b10, 1'b0, 1'b0, 32'h10,  32'h200, 2'b10, 1'b1, 32'h200,  2'b00, 2'b00};
        v[19] = '{2'b01, 1'b0, 1'b0, 32'h10,  32'h200, 2'b10, 1'b0, 32'h200,  2'b00, 2'b00};
        v[20] = '{2'b01, 1'b1, 1'b0, 32'h10,  32'h200, 2'b10, 1'b0, 32'h200,  2'b10, 2'b00};
        v[21] = '{2'b01, 1'b0, 1'b0, 32'h10,  32'h200, 2'b01, 1'b1, 32'h10,   2'b00, 2'b00};
        v[22] = '{2'b01, 1'b1, 1'b0, 32'h10,  32'h200, 2'b01, 1'b1, 32'h10,   2'b01, 2'b00};
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            qm_cs = v[i].cs; qs_ack = v[i].ack; qs_err = v[i].err;
            adr[0] = v[i].a0; adr[1] = v[i].a1;
            pack_bus();
            #1;
            chk($sformatf("vec%0d_ms", i), ms, v[i].e_ms);
            chk($sformatf("vec%0d_qs_cs", i), qs_cs, v[i].e_cs);
            chk($sformatf("vec%0d_qs_adr", i), qs_adr, v[i].e_adr);
            chk($sformatf("vec%0d_ack", i), qm_ack, v[i].e_ack);
            chk($sformatf("vec%0d_err", i), qm_err, v[i].e_err);
            if (v[i].e_ack[1]) chk($sformatf("vec%0d_dat_r1", i), qm_dat_r[63:32], 32'hDEADBEEF);
        end
`else
        begin
            logic [1:0] rr_exp [4];
            rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
            apply_reset();
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                qm_cs = 2'b11; qs_ack = 1'b1;
                #1;
                chk($sformatf("rr%0d_ms", i), ms, rr_exp[i]);
            end
        end
`endif

        apply_reset();
        for (int n = 0; n < 600; n++) begin
            int          g;
            logic [1:0]  e_ms;
            logic [1:0]  cs;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                we[i]  = 1'($urandom);
                sel[i] = 4'($urandom);
                adr[i] = $urandom;
                dat[i] = $urandom;
            end
            pack_bus();
            cs = 2'($urandom);
            qm_cs    = cs;
            qs_ack   = ($urandom_range(0, 3) == 0);
            qs_err   = ($urandom_range(0, 7) == 0);
            qs_dat_r = $urandom;
            #1;
            g = pick(cs);
            e_ms = 2'b00;
            if (g >= 0) e_ms[g] = 1'b1;
            chk("rnd_ms", ms, e_ms);
            chk("rnd_qs_cs", qs_cs, (g >= 0) ? cs[g] : 1'b0);
            chk("rnd_qs_we", qs_we, (g >= 0) ? we[g] : 1'b0);
            chk("rnd_qs_sel", qs_sel, (g >= 0) ? sel[g] : 4'h0);
            chk("rnd_qs_adr", qs_adr, (g >= 0) ? adr[g] : 32'h0);
            chk("rnd_qs_dat_w", qs_dat_w, (g >= 0) ? dat[g] : 32'h0);
            chk("rnd_ack", qm_ack, qs_ack ? e_ms : 2'b00);
            chk("rnd_err", qm_err, qs_err ? e_ms : 2'b00);
            chk("rnd_dat_r", qm_dat_r, {qs_dat_r, qs_dat_r});
            if (g >= 0 && cs[g] && !(qs_ack || qs_err)) begin
                m_busy = 1'b1;
                m_own  = g;
            end else if (qs_ack || qs_err) begin
                m_busy = 1'b0;
            end
            if ((qs_ack || qs_err) && g >= 0) m_last = g;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/qmem_master_arbiter.md
Name: qmem_master_arbiter

Overview:
- N-master to 1-slave arbiter for the QMEM bus (cs/we/sel/adr/dat_w request, dat_r/ack/err response).
- Sits in front of each shared slave (ROM, DRAM) in the QMEM interconnect; masters arrive from per-master address decoders.
- Selects one requesting master, forwards its request to the slave, and routes the slave response back to that master only.
- Holds the grant until the transfer terminates.

Parameters:
- QAW, 32, address width per master/slave
- QDW, 32, data width
- QSW, QDW/8, byte-select width
- MN, 2, number of masters (>=2)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- qm_cs  in  MN  per-master chip select
- qm_we  in  MN  per-master write enable
- qm_sel  in  MN*QSW  byte selects, master i at [i*QSW +: QSW]
- qm_adr  in  MN*QAW  addresses, master i at [i*QAW +: QAW]
- qm_dat_w  in  MN*QDW  write data, master i at [i*QDW +: QDW]
- qm_dat_r  out  MN*QDW  read data per master
- qm_ack  out  MN  per-master acknowledge
- qm_err  out  MN  per-master error
- qs_cs, qs_we  out  1  slave request
- qs_sel  out  QSW  slave byte select
- qs_adr  out  QAW  slave address
- qs_dat_w  out  QDW  slave write data
- qs_dat_r  in  QDW  slave read data
- qs_ack, qs_err  in  1  slave termination
- ms  out  MN  one-hot current grant (all-zero when no grant)

Behaviour:
- State: busy flag and lock register ms_q[MN-1:0]. Reset (rst low, asynchronous): busy=0, ms_q=0.
- While rst is low:
  - qs_cs=0, ms=0, qm_ack=0, qm_err=0.
- Grant:
  - busy=0: ms = fixed-priority one-hot of qm_cs; lowest index wins. No requests gives ms=0.
  - busy=1: ms = ms_q. New requests are ignored, including a higher-priority master.
- Request mux (combinational, zero latency):
  - qs_cs = |(qm_cs & ms).
  - qs_we/sel/adr/dat_w are taken from the granted master.
  - When ms=0, all qs_* outputs are 0.
- Response routing:
  - qm_ack[i] = qs_ack & ms[i]; qm_err[i] = qs_err & ms[i].
  - qm_dat_r[i] = qs_dat_r for every i; masters qualify read data with their own ack.
- Lock, per clock edge:
  - if qs_cs & ~(qs_ack|qs_err): busy<=1, ms_q<=ms.
  - else if qs_ack|qs_err: busy<=0.
- Transfer lengths:
  - Single-cycle transfer (ack in the same cycle as cs) never sets busy.
  - Back-to-back transfers: the next arbitration happens in the cycle after termination.
- Master drop: if the granted master drops cs while busy, qs_cs=0 and the lock stays until ack/err. Slaves must not ack without cs, so a master must not drop cs mid-transfer.
- Simultaneous ack and err: both are forwarded to the granted master, and busy clears.
- Address/data pass through unmodified; width adaptation belongs to the instantiating bus.

Optional Feature:
- QMEM_ARB_RR_EN defined: round-robin priority.
  - A register last_q (reset = MSB one-hot) records the last granted master at each transfer termination.
  - Priority search starts at index last+1, modulo MN.
- Undefined: fixed priority as above, no last_q register.

Decomposition:
- Package qmem_pkg: default QAW/QDW/QSW constants, plus a function onehot_prio(vec) that returns the lowest set bit as one-hot.
- Sub-module qmem_arb_sel: grant selection (fixed or round-robin) plus the busy/ms_q lock. The arbiter top contains only muxing and routing.
- The per-master decoder (1 master to SN slaves) reuses qmem_pkg.

Test Plan:
- Reset: rst low with qm_cs=2'b11 → qs_cs=0, ms=0, qm_ack=0. After rst high → ms=2'b01.
- Single master: m1 reads adr 0x1234, slave acks after 3 cycles with dat_r 0xDEADBEEF → qs_adr=0x1234; ack only on qm_ack[1]; qm_ack[0]=0.
- Contention: m0 and m1 assert cs in the same cycle → m0 served first. m1 is granted in the cycle after m0's ack and its address appears on qs_adr.
- Lock: m1 is mid-transfer (slave stalls 4 cycles) when m0 raises cs → ms stays 2'b10 until ack, then switches to 2'b01.
- Error: slave asserts qs_err=1 for m0's write to 0x10 → qm_err[0]=1, qm_err[1]=0, busy clears, next request arbitrated.
- With QMEM_ARB_RR_EN: both masters request continuously with zero-wait acks → grants alternate 01,10,01,10.
